piso_serial_tx: RTL and testbench
=================================

// Module: piso_serial_tx
// PURPOSE
//  Parallel-in/serial-out transmitter. It is the transmit end of the serial-load
//  path used by the universal shift register.
//  - Accepts a WIDTH-bit word over a valid/ready handshake.
//  - Shifts the word out one bit at a time on sdo, each bit held for CLKS_PER_BIT cycles.
//  - sframe qualifies the bits; bit_strobe marks the start of each bit.
//  - Feeds the serial-load input of a downstream shift register or a serial link.
// PARAMETERS
//  WIDTH         4  bits per word, >= 2
//  MSB_FIRST     1  1: send in_data[WIDTH-1] first; 0: send in_data[0] first
//  CLKS_PER_BIT  1  clk cycles each bit is held on sdo, >= 1
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      reset, asynchronous, active-high
//  in_data     in   WIDTH  word to send; sampled only on accept
//  in_valid    in   1      in_data valid
//  in_ready    out  1      block can accept; high only in IDLE
//  sdo         out  1      serial data out; 0 when sframe=0
//  sframe      out  1      high while sdo carries a frame bit
//  bit_strobe  out  1      1-cycle pulse in the first cycle of each bit
//  busy        out  1      high in SHIFT state
//  done        out  1      1-cycle pulse after the last bit period completes
// BEHAVIOUR
//  - All outputs are registered. Only IDLE->SHIFT entry depends on inputs (in_valid).
//  - Reset (async) forces IDLE and clears the shift register and both counters.
//    Output values during reset: in_ready=1, sdo=0, sframe=0, bit_strobe=0,
//    busy=0, done=0.
//  - States:
//    - IDLE: in_ready=1.
//      - Accept = in_valid & in_ready at a rising edge.
//      - On accept, capture in_data and go to SHIFT.
//      - in_valid=0: stay in IDLE.
//    - SHIFT: in_ready=0 and busy=1. in_valid and in_data are ignored.
//  - Latency: on the edge that accepts the word, the block enters SHIFT.
//    - sdo = first bit, sframe=1, bit_strobe=1 in the very next cycle (1-cycle latency).
//  - Bit timing:
//    - Each bit is held for exactly CLKS_PER_BIT cycles.
//    - A divider counts 0..CLKS_PER_BIT-1 and wraps to 0 at the terminal count.
//    - When the divider wraps, the register shifts (toward the MSB if MSB_FIRST=1,
//      else toward the LSB) and the bit counter increments.
//    - bit_strobe=1 in the first cycle of each bit: WIDTH pulses per frame,
//      CLKS_PER_BIT cycles apart. With CLKS_PER_BIT=1, bit_strobe stays high for
//      the whole frame.
//  - Frame end:
//    - sframe is high for exactly WIDTH*CLKS_PER_BIT consecutive cycles.
//    - At the edge ending the last bit period: return to IDLE with sframe=0,
//      sdo=0, done=1 for one cycle, in_ready=1.
//  - Back-to-back: a word may be accepted in the done cycle. Its first bit then
//    appears in the next cycle, so frames are separated by exactly 1 idle cycle.
//  - Counter widths: $clog2(WIDTH+1) and $clog2(CLKS_PER_BIT+1). No overflow is
//    possible within a frame.
//  - Reset mid-frame: the frame is aborted immediately. No done pulse and no
//    partial bits after reset deasserts; the next accepted word is sent in full.
//  - Ignored input activity: in_data changes after accept, and in_valid pulses
//    during SHIFT, have no effect.
// TESTING
//  Default parameters (WIDTH=4, CLKS_PER_BIT=1) unless stated. Cycle 1 = first cycle after the accept edge.
//  1. Reset, with in_valid=1 and in_data=4'hF applied during reset -> all outputs
//     hold reset values; no accept while reset=1.
//  2. MSB_FIRST=1, accept 4'b1011 -> sdo=1,0,1,1 in cycles 1-4; sframe=1 in cycles
//     1-4; done=1 in cycle 5 only; in_ready=0 in cycles 1-4.
//  3. MSB_FIRST=0, accept 4'b1011 -> sdo=1,1,0,1 in cycles 1-4; done in cycle 5.
//  4. CLKS_PER_BIT=3, MSB_FIRST=1, accept 4'b0110 -> sdo=0,0,0,1,1,1,1,1,1,0,0,0
//     over cycles 1-12; bit_strobe in cycles 1,4,7,10; done in cycle 13.
//  5. in_valid held high with 4'b1011, then 4'b0100 presented in the done cycle ->
//     second word accepted in cycle 5; sframe=0 in cycle 5; sdo=0,1,0,0 in cycles 6-9.
//  6. Reset asserted in cycle 2 of a 4'b1111 frame -> sdo/sframe/busy drop to 0
//     asynchronously; no done; next word 4'b1001 transmits fully: 1,0,0,1.

Source files
------------

// File: rtl/piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_serial_tx
// Brief    : Parallel-in/serial-out transmitter with valid/ready word intake,
//            per-bit hold of CLKS_PER_BIT cycles and framing/strobe outputs.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serial_tx #(
    parameter int WIDTH        = 4,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdo,
    output logic             sframe,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int c_BIT_CNT_W = $clog2(WIDTH + 1);
    localparam int c_DIV_CNT_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [c_BIT_CNT_W-1:0] c_BIT_LAST = c_BIT_CNT_W'(WIDTH - 1);
    localparam logic [c_DIV_CNT_W-1:0] c_DIV_LAST = c_DIV_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_ONE  = c_BIT_CNT_W'(1);
    localparam logic [c_DIV_CNT_W-1:0] c_DIV_ONE  = c_DIV_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                   r_state;
    logic [WIDTH-1:0]         r_shreg;
    logic [c_DIV_CNT_W-1:0]   r_div;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt;
    logic                     r_in_ready;
    logic                     r_sdo;
    logic                     r_sframe;
    logic                     r_bit_strobe;
    logic                     r_busy;
    logic                     r_done;

    logic [WIDTH-1:0]         w_shifted;
    logic                     w_first_bit;
    logic                     w_next_bit;
    logic                     w_accept;
    logic                     w_div_wrap;
    logic                     w_last_bit;

    // The register rotates; the bit wrapped into the far end is never sent
    // because the frame ends after WIDTH bits.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted   = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
            assign w_first_bit = in_data[WIDTH-1];
            assign w_next_bit  = r_shreg[WIDTH-2];
        end else begin : g_lsb_first
            assign w_shifted   = {r_shreg[0], r_shreg[WIDTH-1:1]};
            assign w_first_bit = in_data[0];
            assign w_next_bit  = r_shreg[1];
        end
    endgenerate

    assign w_accept   = in_valid & r_in_ready;
    assign w_div_wrap = (r_div == c_DIV_LAST);
    assign w_last_bit = (r_bit_cnt == c_BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_div        <= '0;
            r_bit_cnt    <= '0;
            r_in_ready   <= 1'b1;
            r_sdo        <= 1'b0;
            r_sframe     <= 1'b0;
            r_bit_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state      <= S_SHIFT;
                        r_shreg      <= in_data;
                        r_div        <= '0;
                        r_bit_cnt    <= '0;
                        r_in_ready   <= 1'b0;
                        r_sdo        <= w_first_bit;
                        r_sframe     <= 1'b1;
                        r_bit_strobe <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_in_ready   <= 1'b1;
                        r_sdo        <= 1'b0;
                        r_sframe     <= 1'b0;
                        r_bit_strobe <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    if (!w_div_wrap) begin
                        r_div        <= r_div + c_DIV_ONE;
                        r_bit_strobe <= 1'b0;
                    end else if (w_last_bit) begin
                        // Last bit period ends here: the done cycle is an IDLE cycle.
                        r_state      <= S_IDLE;
                        r_div        <= '0;
                        r_bit_cnt    <= '0;
                        r_in_ready   <= 1'b1;
                        r_sdo        <= 1'b0;
                        r_sframe     <= 1'b0;
                        r_bit_strobe <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_div        <= '0;
                        r_bit_cnt    <= r_bit_cnt + c_BIT_ONE;
                        r_shreg      <= w_shifted;
                        r_sdo        <= w_next_bit;
                        r_bit_strobe <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_in_ready   <= 1'b1;
                    r_sdo        <= 1'b0;
                    r_sframe     <= 1'b0;
                    r_bit_strobe <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign sdo        = r_sdo;
    assign sframe     = r_sframe;
    assign bit_strobe = r_bit_strobe;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serial_tx
// Brief    : Self-checking bench for piso_serial_tx across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_valid;
    logic [3:0] in_data [3];
    logic [2:0] in_ready, sdo, sframe, bit_strobe, busy, done;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  sim_done = 1'b0;

    // Model state: m_t = cycle index inside the frame (0 = not sending).
    int         m_t    [3];
    logic [3:0] m_word [3];
    logic       m_done [3];

    always #5 clk = ~clk;

    // Instance 0: MSB first, 1 clk/bit; 1: LSB first, 1 clk/bit; 2: MSB first, 3 clk/bit.
    piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .CLKS_PER_BIT(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .sdo(sdo[0]), .sframe(sframe[0]),
        .bit_strobe(bit_strobe[0]), .busy(busy[0]), .done(done[0]));

    piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .sdo(sdo[1]), .sframe(sframe[1]),
        .bit_strobe(bit_strobe[1]), .busy(busy[1]), .done(done[1]));

    piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .CLKS_PER_BIT(3)) u_dut2 (
        .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .sdo(sdo[2]), .sframe(sframe[2]),
        .bit_strobe(bit_strobe[2]), .busy(busy[2]), .done(done[2]));

    function automatic int cpb_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int k);
        return (k != 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_t[k]    <= 0;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_t[k] == 0) begin
                    m_done[k] <= 1'b0;
                    if (in_valid[k]) begin
                        m_word[k] <= in_data[k];
                        m_t[k]    <= 1;
                    end
                end else if (m_t[k] == 4 * cpb_of(k)) begin
                    m_t[k]    <= 0;
                    m_done[k] <= 1'b1;
                end else begin
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    // Expected {in_ready, sdo, sframe, bit_strobe, busy, done}
    function automatic logic [5:0] model_out(input int k);
        int   i;
        int   idx;
        logic b;
        if (reset)
            return 6'b100000;
        if (m_t[k] == 0)
            return {1'b1, 4'b0000, m_done[k]};
        i   = m_t[k] - 1;
        idx = i / cpb_of(k);
        b   = msb_of(k) ? m_word[k][3 - idx] : m_word[k][idx];
        return {1'b0, b, 1'b1, (i % cpb_of(k)) == 0, 1'b1, 1'b0};
    endfunction

    function automatic logic [5:0] dut_out(input int k);
        return {in_ready[k], sdo[k], sframe[k], bit_strobe[k], busy[k], done[k]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        while (!sim_done) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                chk($sformatf("model_inst%0d", k), 32'(dut_out(k)), 32'(model_out(k)));
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Sends a word on instance k, checks the sdo sequence and the done pulse.
    task automatic send_and_check(input int k, input string tag, input logic [3:0] word,
                                  input logic [3:0] exp_bits);
        in_data[k]  = word;
        in_valid[k] = 1'b1;
        step();
        in_valid[k] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s_sdo_c%0d", tag, c + 1), 32'(sdo[k]), 32'(exp_bits[3 - c]));
            chk($sformatf("%s_sframe_c%0d", tag, c + 1), 32'(sframe[k]), 32'd1);
            chk($sformatf("%s_ready_c%0d", tag, c + 1), 32'(in_ready[k]), 32'd0);
            step();
        end
        chk($sformatf("%s_done_c5", tag), 32'(done[k]), 32'd1);
        chk($sformatf("%s_sframe_c5", tag), 32'(sframe[k]), 32'd0);
        step();
        chk($sformatf("%s_done_c6", tag), 32'(done[k]), 32'd0);
    endtask

    initial begin
        logic [11:0] slow_sdo;
        reset    = 1'b1;
        in_valid = 3'b111;
        for (int k = 0; k < 3; k++) in_data[k] = 4'hF;
        fork
            compare_loop();
        join_none

        // Reset with valid input pending: nothing accepted
        step(3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_vals_inst%0d", k), 32'(dut_out(k)), 32'h20);
        in_valid = 3'b000;
        reset    = 1'b0;
        step();
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_ready", 32'(in_ready), 32'h7);

        // MSB first and LSB first, one clock per bit
        send_and_check(0, "msb1011", 4'b1011, 4'b1011);
        send_and_check(1, "lsb1011", 4'b1011, 4'b1101);

        // Three clocks per bit
        slow_sdo    = 12'b000111111000;
        in_data[2]  = 4'b0110;
        in_valid[2] = 1'b1;
        step();
        in_valid[2] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("slow_sdo_c%0d", c + 1), 32'(sdo[2]), 32'(slow_sdo[11 - c]));
            chk($sformatf("slow_strobe_c%0d", c + 1), 32'(bit_strobe[2]),
                32'((c % 3) == 0));
            step();
        end
        chk("slow_done_c13", 32'(done[2]), 32'd1);
        step();

        // Back-to-back: valid held high, second word presented during the frame
        in_data[0]  = 4'b1011;
        in_valid[0] = 1'b1;
        step();
        in_data[0]  = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("b2b_first_c%0d", c + 1), 32'(sdo[0]), 32'(4'b1011 >> (3 - c)) & 32'd1);
            step();
        end
        chk("b2b_sframe_c5", 32'(sframe[0]), 32'd0);
        chk("b2b_done_c5", 32'(done[0]), 32'd1);
        chk("b2b_ready_c5", 32'(in_ready[0]), 32'd1);
        step();
        in_valid[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("b2b_second_c%0d", c + 6), 32'(sdo[0]), 32'(4'b0100 >> (3 - c)) & 32'd1);
            chk($sformatf("b2b_sframe_c%0d", c + 6), 32'(sframe[0]), 32'd1);
            step();
        end
        chk("b2b_done_c10", 32'(done[0]), 32'd1);
        step(2);

        // Reset in cycle 2 of a frame aborts it asynchronously
        in_data[0]  = 4'b1111;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        step();
        chk("abort_sdo_before", 32'(sdo[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_sdo_async", 32'(sdo[0]), 32'd0);
        chk("abort_sframe_async", 32'(sframe[0]), 32'd0);
        chk("abort_busy_async", 32'(busy[0]), 32'd0);
        step(2);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("abort_no_done_%0d", c), 32'(done[0]), 32'd0);
            chk($sformatf("abort_no_frame_%0d", c), 32'(sframe[0]), 32'd0);
        end
        send_and_check(0, "after_abort", 4'b1001, 4'b1001);

        step(2);
        sim_done = 1'b1;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
